// File: rtl/lane_mux_pkg.sv
// Shared PHY TX/RX lane definitions: byte width, lane selector, lane ids.
// Imported by lane_mux and lane_fifo.
package lane_mux_pkg;

   localparam int LANE_DATA_W = 8;

   typedef enum logic {
      SEL0 = 1'b0,
      SEL1 = 1'b1
   } sel_t;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/lane_mux_fifo.sv
// lane_fifo: per-lane synchronous FIFO with first-word-fall-through read.
// dout always shows the head entry so pop and capture share one edge.
module lane_fifo
   import lane_mux_pkg::*;
#(
   parameter int DATA_W = LANE_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; stale entries are never read past count.
   always_ff @(posedge clk_2f) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/lane_mux.sv
// lane_mux: two-lane TX interleaver, lane 0 then lane 1, gap restarts at lane 0.
// Define LANE_MUX_PAIR_EN for pair-atomic mode (lane 0 waits for lane 1).
module lane_mux
   import lane_mux_pkg::*;
#(
   parameter int DATA_W     = LANE_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in_0,
   input  logic              valid_in_0,
   output logic              ready_out_0,
   input  logic [DATA_W-1:0] data_in_1,
   input  logic              valid_in_1,
   output logic              ready_out_1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              lane_out,
   output logic              overflow_out
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_W-1:0] dout_0, dout_1;
   logic              empty_0, empty_1;
   logic              full_0, full_1;
   logic [CNT_W-1:0]  count_0, count_1;
   logic              push_0, push_1;
   logic              pop_0, pop_1;
   logic              can_0;
   sel_t              sel_q, sel_d;

   assign ready_out_0 = (count_0 < CNT_W'(FIFO_DEPTH));
   assign ready_out_1 = (count_1 < CNT_W'(FIFO_DEPTH));
   assign push_0      = valid_in_0 & ~full_0;
   assign push_1      = valid_in_1 & ~full_1;

`ifdef LANE_MUX_PAIR_EN
   assign can_0 = ~empty_0 & ~empty_1;
`else
   assign can_0 = ~empty_0;
`endif

   lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo_0 (
      .clk_2f (clk_2f),
      .reset  (reset),
      .push   (push_0),
      .pop    (pop_0),
      .din    (data_in_0),
      .dout   (dout_0),
      .empty  (empty_0),
      .full   (full_0),
      .count  (count_0)
   );

   lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo_1 (
      .clk_2f (clk_2f),
      .reset  (reset),
      .push   (push_1),
      .pop    (pop_1),
      .din    (data_in_1),
      .dout   (dout_1),
      .empty  (empty_1),
      .full   (full_1),
      .count  (count_1)
   );

   // Any cycle without a pop falls back to SEL0.
   always_comb begin
      sel_d = SEL0;
      pop_0 = 1'b0;
      pop_1 = 1'b0;
      unique case (sel_q)
         SEL0: begin
            if (can_0) begin
               pop_0 = 1'b1;
               sel_d = SEL1;
            end
         end
         SEL1: begin
            if (!empty_1) pop_1 = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         sel_q        <= SEL0;
         data_out     <= '0;
         valid_out    <= 1'b0;
         lane_out     <= LANE0;
         overflow_out <= 1'b0;
      end else begin
         sel_q     <= sel_d;
         valid_out <= pop_0 | pop_1;
         if (pop_0) begin
            data_out <= dout_0;
            lane_out <= LANE0;
         end else if (pop_1) begin
            data_out <= dout_1;
            lane_out <= LANE1;
         end
         overflow_out <= overflow_out
                       | (valid_in_0 & ~ready_out_0)
                       | (valid_in_1 & ~ready_out_1);
      end
   end

endmodule

// File: tb/tb_lane_mux.sv
// tb_lane_mux: scoreboard bench for lane_mux, default and pair-atomic builds.
// Expected (lane, byte) entries are queued at stimulus time, popped on valid_out.
module tb_lane_mux;

   import lane_mux_pkg::*;

`ifdef LANE_MUX_PAIR_EN
   localparam bit PAIR = 1'b1;
`else
   localparam bit PAIR = 1'b0;
`endif

   typedef struct packed {
      logic       lane;
      logic [7:0] data;
   } exp_t;

   logic       clk_2f = 1'b0;
   logic       reset;
   logic [7:0] data_in_0, data_in_1;
   logic       valid_in_0, valid_in_1;
   logic       ready_out_0, ready_out_1;
   logic [7:0] data_out;
   logic       valid_out;
   logic       lane_out;
   logic       overflow_out;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk_2f = ~clk_2f;

   lane_mux #(
      .DATA_W     (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_2f       (clk_2f),
      .reset        (reset),
      .data_in_0    (data_in_0),
      .valid_in_0   (valid_in_0),
      .ready_out_0  (ready_out_0),
      .data_in_1    (data_in_1),
      .valid_in_1   (valid_in_1),
      .ready_out_1  (ready_out_1),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .lane_out     (lane_out),
      .overflow_out (overflow_out)
   );

   always @(negedge clk_2f) begin
      exp_t e;
      if (valid_out === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got lane=%0d data=%h, required no output",
                     lane_out, data_out);
         end else begin
            e = sb.pop_front();
            if ({lane_out, data_out} !== {e.lane, e.data})
               $display("FAIL sb_data: got lane=%0d data=%h, required lane=%0d data=%h",
                        lane_out, data_out, e.lane, e.data);
            else
               n_pass++;
         end
      end
   end

   task automatic idle();
      valid_in_0 = 1'b0;
      valid_in_1 = 1'b0;
   endtask

   task automatic drive(input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1);
      valid_in_0 = v0;
      data_in_0  = d0;
      valid_in_1 = v1;
      data_in_1  = d1;
   endtask

   task automatic test_reset();
      @(negedge clk_2f);
      reset = 1'b1;
      idle();
      @(negedge clk_2f);
      sb.delete();
      n_checks++;
      if ({valid_out, data_out, lane_out, overflow_out, ready_out_0, ready_out_1}
          !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1})
         $display("FAIL reset_state: got v=%b d=%h l=%b ovf=%b r0=%b r1=%b, required 0 00 0 0 1 1",
                  valid_out, data_out, lane_out, overflow_out, ready_out_0, ready_out_1);
      else
         n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_interleave();
      logic [5:0] vp;
      sb.push_back({LANE0, 8'hA0});
      sb.push_back({LANE1, 8'hB0});
      sb.push_back({LANE0, 8'hA1});
      sb.push_back({LANE1, 8'hB1});
      for (int i = 0; i < 6; i++) begin
         if (i == 0)      drive(1'b1, 8'hA0, 1'b1, 8'hB0);
         else if (i == 1) drive(1'b1, 8'hA1, 1'b1, 8'hB1);
         else             idle();
         @(negedge clk_2f);
         vp[i] = valid_out;
      end
      n_checks++;
      if (vp !== 6'b011110)
         $display("FAIL interleave_timing: got valid pattern %b, required 011110", vp);
      else
         n_pass++;
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL interleave_drain: got %0d pending, required 0", sb.size());
      else
         n_pass++;
   endtask

   task automatic test_lane0_only();
      logic [4:0] vp;
      logic [5:0] vp2;
      sb.push_back({LANE0, 8'h11});
      if (PAIR) sb.push_back({LANE1, 8'h33});
      sb.push_back({LANE0, 8'h22});
      if (PAIR) sb.push_back({LANE1, 8'h44});
      for (int i = 0; i < 5; i++) begin
         if (i == 0)      drive(1'b1, 8'h11, 1'b0, 8'h00);
         else if (i == 1) drive(1'b1, 8'h22, 1'b0, 8'h00);
         else             idle();
         @(negedge clk_2f);
         vp[i] = valid_out;
      end
      n_checks++;
      if (vp !== (PAIR ? 5'b00000 : 5'b01010))
         $display("FAIL lane0_gap: got valid pattern %b, required %b",
                  vp, PAIR ? 5'b00000 : 5'b01010);
      else
         n_pass++;
      if (PAIR) begin
         for (int i = 0; i < 6; i++) begin
            if (i == 0)      drive(1'b0, 8'h00, 1'b1, 8'h33);
            else if (i == 1) drive(1'b0, 8'h00, 1'b1, 8'h44);
            else             idle();
            @(negedge clk_2f);
            vp2[i] = valid_out;
         end
         n_checks++;
         if (vp2 !== 6'b011110)
            $display("FAIL pair_release: got valid pattern %b, required 011110", vp2);
         else
            n_pass++;
      end
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL lane0_drain: got %0d pending, required 0", sb.size());
      else
         n_pass++;
   endtask

   task automatic test_lane1_first();
      logic [3:0] vp;
      logic [3:0] vp2;
      sb.push_back({LANE0, 8'h66});
      sb.push_back({LANE1, 8'h55});
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b0, 8'h00, 1'b1, 8'h55);
         else        idle();
         @(negedge clk_2f);
         vp[i] = valid_out;
      end
      n_checks++;
      if (vp !== 4'b0000)
         $display("FAIL lane1_hold: got valid pattern %b, required 0000", vp);
      else
         n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b1, 8'h66, 1'b0, 8'h00);
         else        idle();
         @(negedge clk_2f);
         vp2[i] = valid_out;
      end
      n_checks++;
      if (vp2 !== 4'b0110)
         $display("FAIL lane1_release: got valid pattern %b, required 0110", vp2);
      else
         n_pass++;
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL lane1_drain: got %0d pending, required 0", sb.size());
      else
         n_pass++;
   endtask

   // Default build drains lane 0 at one byte per two cycles, so it
   // takes 7 pushes to reach 4 entries; pair mode never drains.
   task automatic test_overflow();
      int nfill;
      nfill = PAIR ? 4 : 7;
      for (int i = 0; i < nfill; i++) begin
         if (!PAIR) sb.push_back({LANE0, 8'(8'hF0 + i)});
         drive(1'b1, 8'(8'hF0 + i), 1'b0, 8'h00);
         @(negedge clk_2f);
         if (i == nfill - 2) begin
            n_checks++;
            if ({ready_out_0, overflow_out} !== 2'b10)
               $display("FAIL ovf_not_full: got ready0=%b ovf=%b, required 1 0",
                        ready_out_0, overflow_out);
            else
               n_pass++;
         end
         if (i == nfill - 1) begin
            n_checks++;
            if ({ready_out_0, overflow_out} !== 2'b00)
               $display("FAIL ovf_full: got ready0=%b ovf=%b, required 0 0",
                        ready_out_0, overflow_out);
            else
               n_pass++;
         end
      end
      drive(1'b1, 8'hEE, 1'b0, 8'h00);
      @(negedge clk_2f);
      idle();
      n_checks++;
      if (overflow_out !== 1'b1)
         $display("FAIL ovf_set: got %b, required 1", overflow_out);
      else
         n_pass++;
      repeat (10) @(negedge clk_2f);
      n_checks++;
      if (overflow_out !== 1'b1)
         $display("FAIL ovf_sticky: got %b, required 1", overflow_out);
      else
         n_pass++;
      n_checks++;
      if (ready_out_0 !== !PAIR)
         $display("FAIL ovf_ready_after: got %b, required %b", ready_out_0, !PAIR);
      else
         n_pass++;
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL ovf_drain: got %0d pending, required 0", sb.size());
      else
         n_pass++;
   endtask

   task automatic test_reset_midstream();
      logic [3:0] vp;
      sb.push_back({LANE0, 8'hC0});
      sb.push_back({LANE1, 8'hD0});
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'hC0 + i), 1'b1, 8'(8'hD0 + i));
         @(negedge clk_2f);
      end
      idle();
      reset = 1'b1;
      @(negedge clk_2f);
      n_checks++;
      if ({valid_out, data_out, overflow_out, ready_out_0, ready_out_1}
          !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b1})
         $display("FAIL mid_reset_state: got v=%b d=%h ovf=%b r0=%b r1=%b, required 0 00 0 1 1",
                  valid_out, data_out, overflow_out, ready_out_0, ready_out_1);
      else
         n_pass++;
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL mid_pre_reset: got %0d pending, required 0", sb.size());
      else
         n_pass++;
      reset = 1'b0;
      sb.push_back({LANE0, 8'h77});
      sb.push_back({LANE1, 8'h78});
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b1, 8'h77, 1'b1, 8'h78);
         else        idle();
         @(negedge clk_2f);
         vp[i] = valid_out;
      end
      n_checks++;
      if (vp !== 4'b0110)
         $display("FAIL mid_restart: got valid pattern %b, required 0110", vp);
      else
         n_pass++;
      n_checks++;
      if (sb.size() != 0)
         $display("FAIL mid_drain: got %0d pending, required 0", sb.size());
      else
         n_pass++;
   endtask

   initial begin
      reset     = 1'b1;
      data_in_0 = 8'h00;
      data_in_1 = 8'h00;
      idle();
      test_reset();
      test_interleave();
      test_lane0_only();
      test_lane1_first();
      test_overflow();
      test_reset();
      test_reset_midstream();
      repeat (2) @(negedge clk_2f);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lane_mux.md
# lane_mux

Transmit-side two-lane interleaver for the PHY TX path; the counterpart of the RX lane demux. Accepts bytes on two independent lanes, buffers each in a small FIFO, and emits them as one serial byte stream on `clk_2f`, strictly alternating lane 0 then lane 1. A gap in the output stream always restarts the pattern at lane 0, matching the RX rule that the first valid byte after idle belongs to lane 0.

## Interface
- `DATA_W`, 8: byte width per lane and on the output.
- `FIFO_DEPTH`, 4: entries per lane FIFO; power of two, ≥ 2.

- `clk_2f`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `data_in_0`  in  DATA_W  lane 0 byte.
- `valid_in_0`  in  1  lane 0 byte present; written when `ready_out_0`=1.
- `ready_out_0`  out  1  lane 0 FIFO not full (registered count).
- `data_in_1`, `valid_in_1`, `ready_out_1`: same for lane 1.
- `data_out`  out  DATA_W  serial byte stream.
- `valid_out`  out  1  `data_out` valid this cycle.
- `lane_out`  out  1  source lane of current `data_out`.
- `overflow_out`  out  1  sticky; set when `valid_in_x`=1 while `ready_out_x`=0.

## Operation
- Reset (synchronous, active-high): FIFOs emptied, `selector`=0, `data_out`=0, `valid_out`=0, `lane_out`=0, `overflow_out`=0, `ready_out_0/1`=1.
- Lane write: `valid_in_x`=1 and `ready_out_x`=1 → byte pushed. `valid_in_x`=1 with `ready_out_x`=0 → byte dropped, `overflow_out` set, remains set until reset.
- `ready_out_x` = (count_x < FIFO_DEPTH), computed from the registered count. A pop in the same cycle does not free space for a push that cycle.
- Arbiter states: `SEL0` (next byte from lane 0) and `SEL1` (next byte from lane 1).
  - `SEL0`, FIFO0 non-empty: pop lane 0; `data_out` = byte, `valid_out`=1, `lane_out`=0; go to `SEL1`.
  - `SEL1`, FIFO1 non-empty: pop lane 1; `valid_out`=1, `lane_out`=1; go to `SEL0`.
  - Selected FIFO empty: `valid_out`=0; `data_out` holds its last value; go to `SEL0`. The gap resets the pattern.
- Consequence: lane 1 empty after a lane 0 byte gives lane0, gap, lane0 …; the RX demux maps both lane 0 bytes correctly.
- Simultaneous push and pop on the same FIFO: both take effect; count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- A byte accepted at edge N is visible on `data_out`/`valid_out` after edge N+1 at the earliest (one registered stage after the FIFO write).
- With both lanes continuously non-empty, output throughput is 1 byte per `clk_2f` cycle, alternating lanes.
- Reset asserted mid-stream: at the next edge all state returns to reset values and in-flight FIFO contents are discarded. The first output after reset release comes from lane 0.
- `ready_out_x` changes only on clock edges.

## Configuration
- `LANE_MUX_PAIR_EN`
  - Defined: pair-atomic mode. In `SEL0`, lane 0 is popped only when both FIFO0 and FIFO1 are non-empty; otherwise the cycle is a gap. A lane 0 byte is therefore always followed immediately by a lane 1 byte, and no lane0–gap–lane0 sequence occurs.
  - Undefined: behaviour as in Operation.

## Structure
- Shared PHY package:
  - `DATA_W` default.
  - Lane selector enum `{SEL0, SEL1}`, shared with the RX demux.
  - Lane index constants `LANE0=0`, `LANE1=1`.
- Sub-module `lane_fifo`, instantiated twice: synchronous FIFO with push, pop, `dout`, `empty`, `full`, `count`; first-word-fall-through read so a pop and `data_out` load happen on the same edge.
- The arbiter and output register live in `lane_mux`.

## Test plan
- Reset then both lanes push 0xA0,0xA1 (lane 0) and 0xB0,0xB1 (lane 1) in the same cycles → `data_out` sequence A0,B0,A1,B1 on consecutive cycles; `lane_out` 0,1,0,1; first valid byte two edges after the first push.
- Lane 0 only pushes 0x11,0x22 → 0x11, one gap cycle (`valid_out`=0), 0x22; `lane_out`=0 for both. With `LANE_MUX_PAIR_EN` defined → no output until lane 1 pushes.
- Lane 1 only pushes 0x55 → no output; then lane 0 pushes 0x66 → output 0x66 then 0x55.
- Fill lane 0 with 5 pushes while the output is blocked (lane 1 empty, `LANE_MUX_PAIR_EN` defined) → `ready_out_0`=0 after the 4th push; the 5th byte is dropped and `overflow_out`=1 and stays 1.
- Reset asserted mid-stream with 3 bytes queued per lane → next cycle `valid_out`=0, FIFOs empty, `ready_out_0/1`=1, `overflow_out`=0; after release, a new push 0x77 on lane 0 is output first.
